fp_issue: RTL and testbench
===========================

# fp_issue

Issue and writeback-sequencing stage directly upstream of the FP ALU. It accepts one decoded FP instruction per cycle with a valid/ready handshake and forwards in-flight results into its operands. It drives the ALU's A/B/Op inputs and tracks each op through the ALU's one-cycle registered latency. Results go out on a valid/ready writeback port, with a one-entry skid register so an ALU result is never lost when writeback stalls.

## Interface
- DATA_W, 32, operand/result width
- REG_W, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- in_op  in  4  ALU opcode
- in_rs1, in_rs2  in  REG_W  source indices for A, B
- in_rd  in  REG_W  destination index
- in_a, in_b  in  DATA_W  register-file read values for rs1, rs2
- alu_a, alu_b  out  DATA_W  ALU operands, after forwarding
- alu_op  out  4  ALU opcode
- alu_out  in  DATA_W  ALU result, valid the cycle after issue
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts result
- wb_rd  out  REG_W  destination index
- wb_int  out  1  1 = integer register file, 0 = FP register file
- wb_data  out  DATA_W  result

## Operation
- Opcodes: 0000 add, 1111 sub, 0010 mul, 1100 eq, 1110 le, 1101 lt, 0100 int→fp, 0101 fp→int. Every other code is a move (pass A).
- Destination class: integer for 1100, 1110, 1101, 0101; FP otherwise.
- Source A class: integer for 0100; FP otherwise. Source B class is always FP.
- State: E stage (e_valid, e_rd, e_int) holds the op currently inside the ALU. S skid holds s_valid, s_rd, s_int, s_data.
- Invariant: e_valid and s_valid are never both 1.
- in_ready = rst_n & ~s_valid & ~(e_valid & ~wb_ready).
- Issue on in_valid & in_ready. Next cycle: e_valid=1, e_rd=in_rd, e_int=dest class.
- No issue leaves e_valid=0 next cycle. The ALU still computes; that result is ignored.
- Forwarding for each source, highest priority first:
  - index/class match with E (e_valid) → use alu_out;
  - match with S (s_valid) → use s_data;
  - otherwise use in_a / in_b.
- A match requires equal index and equal register class. Integer index 0 is never forwarded.
- alu_a, alu_b and alu_op are combinational from the in_* inputs plus the forwarding muxes, and are driven regardless of in_valid.
- Writeback output:
  - s_valid=1 → wb_* from S;
  - else e_valid=1 → wb_data=alu_out, wb_rd=e_rd, wb_int=e_int;
  - else wb_valid=0.
- E to S: when e_valid & ~wb_ready, S loads {alu_out, e_rd, e_int} and s_valid goes to 1.
- S drain: s_valid & wb_ready clears s_valid. No issue happens in that cycle, giving a one-cycle bubble.
- wb_* are held stable while wb_valid & ~wb_ready.

## Timing
- Issue-to-wb_valid latency: 1 cycle when unstalled. Sustained throughput is 1 op/cycle while wb_ready=1.
- in_ready depends combinationally on wb_ready. wb_data depends combinationally on alu_out.
- Reset (asynchronous assert, synchronous-to-clk release): e_valid=0, s_valid=0, s_data=0, wb_valid=0, in_ready=0 while rst_n=0.
- Reset mid-operation discards in-flight E and S contents. No writeback is produced for them.
- wb_ready drops while E is valid: the result moves to S that cycle and no new op is accepted.
- Back-to-back dependent ops (rd of op N = rs of op N+1, same class) issue with no stall through alu_out forwarding.

## Structure
- Shared package fp_pkg holds:
  - localparams for the nine opcodes;
  - function fp_dest_is_int(op);
  - function fp_srcA_is_int(op).
- The FP ALU uses the same package constants.
- Sub-module fp_wb_skid: the one-entry skid register plus output mux, taking E and S inputs and driving wb_*, s_valid, s_rd, s_int and s_data. The forwarding logic in fp_issue reads s_valid, s_rd, s_int and s_data from it.

## Test plan
- Reset, then issue add rd=3 (A=0x3F800000, B=0x40000000) with wb_ready=1 → next cycle wb_valid=1, wb_rd=3, wb_int=0, wb_data=0x40400000.
- Dependent chain: op0 mul f1=f2*f3, then op1 add f4=f1+f5 the following cycle → op1's alu_a equals op0's alu_out. No in_ready deassertion.
- Stall: wb_ready=0 for 3 cycles after an issue → result held in S. in_ready=0 throughout and for the drain cycle. wb_data stays constant. Exactly one writeback once wb_ready=1.
- Class isolation: lt into integer rd=1, then add f3=f1+f2 → no forwarding, alu_a=in_a. Integer rd=0 result with an int→fp rs1=0 → no forwarding.
- Assert rst_n=0 while s_valid=1 → wb_valid=0 immediately. After release, no stale writeback and in_ready=1.
- Random valid/ready traffic over 10k ops → every accepted op produces exactly one in-order writeback whose data matches a reference model.

Source files
------------

// File: rtl/fp_pkg.sv
// Opcode constants and register-class helpers shared by the FP issue stage and FP ALU.
package fp_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_EQ  = 4'b1100;
  localparam logic [3:0] OP_LE  = 4'b1110;
  localparam logic [3:0] OP_LT  = 4'b1101;
  localparam logic [3:0] OP_I2F = 4'b0100;
  localparam logic [3:0] OP_F2I = 4'b0101;
  // Any code not listed above behaves as a move; this is the canonical one.
  localparam logic [3:0] OP_MOV = 4'b0001;

  function automatic logic fp_dest_is_int(input logic [3:0] op);
    return (op == OP_EQ) || (op == OP_LE) || (op == OP_LT) || (op == OP_F2I);
  endfunction

  function automatic logic fp_srcA_is_int(input logic [3:0] op);
    return (op == OP_I2F);
  endfunction

endpackage

// File: rtl/fp_wb_skid.sv
// Writeback sequencer: E-stage result straight through, or parked in a one-entry skid.
// Zero added latency; a result stalled by wb_ready low moves to S and is held stable.
module fp_wb_skid #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_e_valid,
  input  logic [REG_W-1:0]  i_e_rd,
  input  logic              i_e_int,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_wb_ready,
  output logic              o_wb_valid,
  output logic [REG_W-1:0]  o_wb_rd,
  output logic              o_wb_int,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_s_valid,
  output logic [REG_W-1:0]  o_s_rd,
  output logic              o_s_int,
  output logic [DATA_W-1:0] o_s_data
);

  logic              r_s_valid;
  logic [REG_W-1:0]  r_s_rd;
  logic              r_s_int;
  logic [DATA_W-1:0] r_s_data;

  // The ALU output is only good for one cycle, so a stalled E result must be captured now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid <= 1'b0;
      r_s_rd    <= '0;
      r_s_int   <= 1'b0;
      r_s_data  <= '0;
    end else if (i_e_valid && !i_wb_ready) begin
      r_s_valid <= 1'b1;
      r_s_rd    <= i_e_rd;
      r_s_int   <= i_e_int;
      r_s_data  <= i_alu_out;
    end else if (r_s_valid && i_wb_ready) begin
      r_s_valid <= 1'b0;
    end
  end

  always_comb begin
    o_wb_valid = r_s_valid | i_e_valid;
    o_wb_rd    = i_e_rd;
    o_wb_int   = i_e_int;
    o_wb_data  = i_alu_out;
    if (r_s_valid) begin
      o_wb_rd   = r_s_rd;
      o_wb_int  = r_s_int;
      o_wb_data = r_s_data;
    end
  end

  assign o_s_valid = r_s_valid;
  assign o_s_rd    = r_s_rd;
  assign o_s_int   = r_s_int;
  assign o_s_data  = r_s_data;

endmodule

// File: rtl/fp_issue.sv
// FP issue stage: forwards in-flight results into ALU operands, tracks the one-cycle ALU op.
// Issue-to-writeback 1 cycle; in_ready drops while S is occupied or an E result is stalled.
module fp_issue
  import fp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_int,
  output logic [DATA_W-1:0] wb_data
);

  logic              r_e_valid;
  logic [REG_W-1:0]  r_e_rd;
  logic              r_e_int;

  logic              w_s_valid;
  logic [REG_W-1:0]  w_s_rd;
  logic              w_s_int;
  logic [DATA_W-1:0] w_s_data;

  logic w_issue;
  logic w_a_int;
  logic w_a_hit_e, w_a_hit_s, w_b_hit_e, w_b_hit_s;

  // Integer x0 is hardwired zero, so a result aimed at it must never be forwarded.
  function automatic logic fwd_hit(input logic vld, input logic [REG_W-1:0] rd,
                                   input logic rd_int, input logic [REG_W-1:0] rs,
                                   input logic rs_int);
    return vld && (rd == rs) && (rd_int == rs_int) && !(rs_int && (rs == '0));
  endfunction

  assign in_ready = rst_n & ~w_s_valid & ~(r_e_valid & ~wb_ready);
  assign w_issue  = in_valid & in_ready;

  assign w_a_int   = fp_srcA_is_int(in_op);
  assign w_a_hit_e = fwd_hit(r_e_valid, r_e_rd, r_e_int, in_rs1, w_a_int);
  assign w_a_hit_s = fwd_hit(w_s_valid, w_s_rd, w_s_int, in_rs1, w_a_int);
  assign w_b_hit_e = fwd_hit(r_e_valid, r_e_rd, r_e_int, in_rs2, 1'b0);
  assign w_b_hit_s = fwd_hit(w_s_valid, w_s_rd, w_s_int, in_rs2, 1'b0);

  always_comb begin
    alu_a = in_a;
    if (w_a_hit_e)      alu_a = alu_out;
    else if (w_a_hit_s) alu_a = w_s_data;
    alu_b = in_b;
    if (w_b_hit_e)      alu_b = alu_out;
    else if (w_b_hit_s) alu_b = w_s_data;
  end

  assign alu_op = in_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid <= 1'b0;
      r_e_rd    <= '0;
      r_e_int   <= 1'b0;
    end else begin
      r_e_valid <= w_issue;
      if (w_issue) begin
        r_e_rd  <= in_rd;
        r_e_int <= fp_dest_is_int(in_op);
      end
    end
  end

  fp_wb_skid #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_wb_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_e_valid  (r_e_valid),
    .i_e_rd     (r_e_rd),
    .i_e_int    (r_e_int),
    .i_alu_out  (alu_out),
    .i_wb_ready (wb_ready),
    .o_wb_valid (wb_valid),
    .o_wb_rd    (wb_rd),
    .o_wb_int   (wb_int),
    .o_wb_data  (wb_data),
    .o_s_valid  (w_s_valid),
    .o_s_rd     (w_s_rd),
    .o_s_int    (w_s_int),
    .o_s_data   (w_s_data)
  );

endmodule

// File: tb/tb_fp_issue.sv
// Bench for fp_issue: directed vectors, then random valid/ready traffic against an in-order model.
module tb_fp_issue;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        wb_valid, wb_ready, wb_int;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_issue #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_int(wb_int), .wb_data(wb_data)
  );

  // Single-precision <-> real via double bit layout (normal numbers only).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Stand-in ALU: real FP for add/sub/mul, simple bit functions for the rest.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      OP_ADD:  return r2f(f2r(a) + f2r(b));
      OP_SUB:  return r2f(f2r(a) - f2r(b));
      OP_MUL:  return r2f(f2r(a) * f2r(b));
      OP_EQ:   return {31'd0, a == b};
      OP_LE:   return {31'd0, a <= b};
      OP_LT:   return {31'd0, a < b};
      OP_I2F:  return a ^ 32'h00FF_00FF;
      OP_F2I:  return ~a;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_fn(alu_op, alu_a, alu_b);

  function automatic logic [63:0] wbx(input logic v, input logic i, input logic [4:0] rd,
                                      input logic [31:0] d);
    return {25'd0, v, i, rd, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic wr);
    in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_a = a; in_b = b; wb_ready = wr;
    #1;
  endtask

  task automatic idle(input logic wr);
    in_valid = 1'b0;
    wb_ready = wr;
    #1;
  endtask

  logic [31:0] rf_fp[32], rf_int[32], sh_fp[32], sh_int[32];
  logic [63:0] expq[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_wb;

  task automatic sample_wb();
    logic [63:0] e;
    if (prev_stall) check("rnd_hold", wbx(wb_valid, wb_int, wb_rd, wb_data), prev_wb);
    prev_stall = wb_valid & ~wb_ready;
    prev_wb    = wbx(wb_valid, wb_int, wb_rd, wb_data);
    if (wb_valid && wb_ready) begin
      if (expq.size() == 0) begin
        check("rnd_extra_wb", 64'(wb_valid), 64'h0);
      end else begin
        e = expq.pop_front();
        check("rnd_wb", wbx(wb_valid, wb_int, wb_rd, wb_data), e);
      end
      if (wb_int) begin
        if (wb_rd != 5'd0) rf_int[wb_rd] = wb_data;
      end else begin
        rf_fp[wb_rd] = wb_data;
      end
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rops[11];
    logic [31:0] av, res;
    logic        aint, dint, need_new;
    int          acc_n, cyc;

    rops = '{OP_EQ, OP_LE, OP_LT, OP_I2F, OP_F2I, 4'b0001, 4'b0011, 4'b0110,
             4'b0111, 4'b1000, 4'b1011};
    rst_n = 1'b0; in_valid = 1'b0; in_op = OP_ADD; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_rd = 5'd0; in_a = 32'd0; in_b = 32'd0; wb_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_wb_valid", 64'(wb_valid), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Basic add: 1.0 + 2.0 -> 3.0 one cycle later.
    drive(1, OP_ADD, 5'd2, 5'd3, 5'd3, 32'h3F80_0000, 32'h4000_0000, 1);
    check("t1_in_ready", 64'(in_ready), 64'h1);
    check("t1_alu_a", 64'(alu_a), 64'h3F80_0000);
    tick();
    idle(1);
    check("t1_wb", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd3, 32'h4040_0000));
    tick();
    check("t1_idle_wb", 64'(wb_valid), 64'h0);

    // Dependent chain through alu_out: f1 = 2*3, f4 = f1 + 1.
    drive(1, OP_MUL, 5'd2, 5'd3, 5'd1, 32'h4000_0000, 32'h4040_0000, 1);
    tick();
    drive(1, OP_ADD, 5'd1, 5'd5, 5'd4, 32'hDEAD_BEEF, 32'h3F80_0000, 1);
    check("t2_in_ready", 64'(in_ready), 64'h1);
    check("t2_fwd_e", 64'(alu_a), 64'h40C0_0000);
    check("t2_wb0", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd1, 32'h40C0_0000));
    tick();
    idle(1);
    check("t2_wb1", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd4, 32'h40E0_0000));
    tick();

    // Stall 3 cycles: result moves to S, pending mov reads f6 via E then S.
    drive(1, OP_ADD, 5'd2, 5'd2, 5'd6, 32'h3F80_0000, 32'h3F80_0000, 1);
    tick();
    drive(1, OP_MOV, 5'd6, 5'd0, 5'd7, 32'hBAD0_BAD0, 32'd0, 0);
    check("t3_in_ready_e", 64'(in_ready), 64'h0);
    check("t3_fwd_e", 64'(alu_a), 64'h4000_0000);
    check("t3_wb_e", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd6, 32'h4000_0000));
    tick();
    for (int i = 0; i < 2; i++) begin
      check("t3_in_ready_s", 64'(in_ready), 64'h0);
      check("t3_fwd_s", 64'(alu_a), 64'h4000_0000);
      check("t3_wb_s", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd6, 32'h4000_0000));
      tick();
    end
    wb_ready = 1'b1;
    #1;
    check("t3_in_ready_drain", 64'(in_ready), 64'h0);
    check("t3_wb_drain", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd6, 32'h4000_0000));
    tick();
    drive(1, OP_MOV, 5'd6, 5'd0, 5'd7, 32'h4000_0000, 32'd0, 1);
    check("t3_in_ready_after", 64'(in_ready), 64'h1);
    check("t3_single_wb", 64'(wb_valid), 64'h0);
    tick();
    idle(1);
    check("t3_wb_mov", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd7, 32'h4000_0000));
    tick();

    // Register-class isolation and integer x0.
    drive(1, OP_LT, 5'd2, 5'd3, 5'd1, 32'h3F80_0000, 32'h4000_0000, 1);
    tick();
    drive(1, OP_ADD, 5'd1, 5'd2, 5'd3, 32'h3F80_0000, 32'h3F80_0000, 1);
    check("t4_no_fwd_class", 64'(alu_a), 64'h3F80_0000);
    check("t4_wb_lt", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 1, 5'd1, 32'd1));
    tick();
    drive(1, OP_EQ, 5'd4, 5'd4, 5'd0, 32'd5, 32'd5, 1);
    check("t4_wb_add", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd3, 32'h4000_0000));
    tick();
    drive(1, OP_I2F, 5'd0, 5'd4, 5'd5, 32'd0, 32'd0, 1);
    check("t4_no_fwd_x0", 64'(alu_a), 64'h0);
    check("t4_wb_x0", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 1, 5'd0, 32'd1));
    tick();
    drive(1, OP_F2I, 5'd4, 5'd4, 5'd2, 32'h0000_00F0, 32'd0, 1);
    check("t4_wb_i2f", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd5, 32'h00FF_00FF));
    tick();
    drive(1, OP_I2F, 5'd2, 5'd4, 5'd6, 32'd0, 32'd0, 1);
    check("t4_fwd_int", 64'(alu_a), 64'hFFFF_FF0F);
    tick();
    idle(1);
    check("t4_wb_fwd_int", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd6, 32'hFF00_FFF0));
    tick();

    // Reset while S holds a result.
    drive(1, OP_MOV, 5'd3, 5'd0, 5'd9, 32'hCAFE_0001, 32'd0, 1);
    tick();
    idle(0);
    tick();
    idle(0);
    check("t5_s_held", wbx(wb_valid, wb_int, wb_rd, wb_data), wbx(1, 0, 5'd9, 32'hCAFE_0001));
    rst_n = 1'b0;
    #1;
    check("t5_rst_wb_valid", 64'(wb_valid), 64'h0);
    check("t5_rst_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    idle(1);
    check("t5_no_stale_wb", 64'(wb_valid), 64'h0);
    check("t5_in_ready", 64'(in_ready), 64'h1);
    tick();
    check("t5_no_stale_wb2", 64'(wb_valid), 64'h0);

    // Random traffic against an in-order architectural model.
    for (int i = 0; i < 32; i++) begin
      rf_fp[i] = $urandom; sh_fp[i] = rf_fp[i];
      rf_int[i] = (i == 0) ? 32'd0 : $urandom; sh_int[i] = rf_int[i];
    end
    acc_n = 0; cyc = 0; need_new = 1'b1; in_valid = 1'b0;
    while (acc_n < 10000 && cyc < 60000) begin
      if (need_new) begin
        if ($urandom_range(0, 7) != 0) begin
          in_valid = 1'b1;
          in_op  = rops[$urandom_range(0, 10)];
          in_rs1 = 5'($urandom_range(0, 7));
          in_rs2 = 5'($urandom_range(0, 7));
          in_rd  = 5'($urandom_range(0, 7));
          need_new = 1'b0;
        end else begin
          in_valid = 1'b0;
        end
      end
      wb_ready = ($urandom_range(0, 3) != 0);
      aint = fp_srcA_is_int(in_op);
      in_a = aint ? rf_int[in_rs1] : rf_fp[in_rs1];
      in_b = rf_fp[in_rs2];
      #1;
      if (in_valid && in_ready) begin
        av   = aint ? sh_int[in_rs1] : sh_fp[in_rs1];
        res  = alu_fn(in_op, av, sh_fp[in_rs2]);
        dint = fp_dest_is_int(in_op);
        expq.push_back(wbx(1, dint, in_rd, res));
        if (dint) begin
          if (in_rd != 5'd0) sh_int[in_rd] = res;
        end else begin
          sh_fp[in_rd] = res;
        end
        acc_n++;
        need_new = 1'b1;
      end
      sample_wb();
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      sample_wb();
      tick();
    end
    check("rnd_accepted", 64'(acc_n), 64'd10000);
    check("rnd_drained", 64'(expq.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
